// File: rtl/seg_driver.sv
// Segment display output stage: registers scan inputs, decodes hex digits, and applies
// anti-ghosting dead time, PWM brightness and leading-zero suppression.
module seg_driver #(
    parameter int unsigned BLANK_CYC   = 2,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          COM_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    input  logic [5:0] seg_sel,
    input  logic [5:0] dp_en,
    input  logic       lzs_en,
    input  logic [3:0] brightness,
    output logic [7:0] seg,
    output logic [5:0] com
);

    localparam logic [7:0] BlankLoad = 8'(BLANK_CYC);
    localparam logic [7:0] SegOff    = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [5:0] ComOff    = COM_ACT_LOW ? 6'h3F : 6'h00;

    logic [3:0] s_d_q, s_d_d;
    logic [5:0] s_sel_q, s_sel_d;
    logic [5:0] s_dp_q, s_dp_d;
    logic [5:0] prev_sel_q, prev_sel_d;
    logic [3:0] digit_mem_q [6];
    logic [3:0] digit_mem_d [6];
    logic [3:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0] blank_cnt_q, blank_cnt_d;
    logic [7:0] seg_q, seg_d;
    logic [5:0] com_q, com_d;

    logic       in_onehot, s_onehot, higher_nz, suppress, show;
    logic [2:0] idx;
    logic [6:0] dec;
    logic [7:0] seg_act;

    always_comb begin
        unique case (s_d_q)
            4'h0: dec = 7'h3F;
            4'h1: dec = 7'h06;
            4'h2: dec = 7'h5B;
            4'h3: dec = 7'h4F;
            4'h4: dec = 7'h66;
            4'h5: dec = 7'h6D;
            4'h6: dec = 7'h7D;
            4'h7: dec = 7'h07;
            4'h8: dec = 7'h7F;
            4'h9: dec = 7'h6F;
            4'hA: dec = 7'h77;
            4'hB: dec = 7'h7C;
            4'hC: dec = 7'h39;
            4'hD: dec = 7'h5E;
            4'hE: dec = 7'h79;
            default: dec = 7'h71;
        endcase
    end

    always_comb begin
        s_d_d    = d;
        s_sel_d  = seg_sel;
        s_dp_d   = dp_en;
        in_onehot = (seg_sel != 6'd0) && ((seg_sel & (seg_sel - 6'd1)) == 6'd0);
        for (int i = 0; i < 6; i++) begin
            digit_mem_d[i] = (in_onehot && seg_sel[i]) ? d : digit_mem_q[i];
        end
        pwm_cnt_d  = pwm_cnt_q + 4'd1;
        prev_sel_d = s_sel_q;

        if (s_sel_q != prev_sel_q) begin
            blank_cnt_d = BlankLoad;
        end else if (blank_cnt_q != 8'd0) begin
            blank_cnt_d = blank_cnt_q - 8'd1;
        end else begin
            blank_cnt_d = 8'd0;
        end

        s_onehot = (s_sel_q != 6'd0) && ((s_sel_q & (s_sel_q - 6'd1)) == 6'd0);
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (s_sel_q[i]) idx = 3'(i);
        end
        higher_nz = 1'b0;
        for (int j = 1; j < 6; j++) begin
            if ((j > int'(idx)) && (digit_mem_q[j] != 4'd0)) higher_nz = 1'b1;
        end
        suppress = lzs_en && (idx != 3'd0) && (s_d_q == 4'd0) && !higher_nz;
        seg_act  = {s_dp_q[idx], suppress ? 7'h00 : dec};

        // The next blank count covers the change edge itself, so BLANK_CYC=0 never blanks.
        show  = s_onehot && (blank_cnt_d == 8'd0) && (pwm_cnt_q < brightness);
        seg_d = (show ? seg_act : 8'h00) ^ SegOff;
        com_d = (show ? s_sel_q : 6'h00) ^ ComOff;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_d_q       <= 4'd0;
            s_sel_q     <= 6'd0;
            s_dp_q      <= 6'd0;
            prev_sel_q  <= 6'd0;
            pwm_cnt_q   <= 4'd0;
            blank_cnt_q <= 8'd0;
            seg_q       <= SegOff;
            com_q       <= ComOff;
            for (int i = 0; i < 6; i++) digit_mem_q[i] <= 4'd0;
        end else begin
            s_d_q       <= s_d_d;
            s_sel_q     <= s_sel_d;
            s_dp_q      <= s_dp_d;
            prev_sel_q  <= prev_sel_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            seg_q       <= seg_d;
            com_q       <= com_d;
            for (int i = 0; i < 6; i++) digit_mem_q[i] <= digit_mem_d[i];
        end
    end

    assign seg = seg_q;
    assign com = com_q;

endmodule

// File: tb/tb_seg_driver.sv
// Directed bench for seg_driver: two instances (BLANK_CYC=0 and 2) share all inputs.
module tb_seg_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d;
    logic [5:0] seg_sel;
    logic [5:0] dp_en;
    logic       lzs_en;
    logic [3:0] brightness;
    logic [7:0] seg0, seg2;
    logic [5:0] com0, com2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference PWM phase: pwm_used is the count the DUT compared on the latest edge.
    logic [3:0] pwm_m, pwm_used;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_m    <= 4'd0;
            pwm_used <= 4'd0;
        end else begin
            pwm_used <= pwm_m;
            pwm_m    <= pwm_m + 4'd1;
        end
    end

    always #5 clk = ~clk;

    seg_driver #(.BLANK_CYC(0), .SEG_ACT_LOW(1'b1), .COM_ACT_LOW(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .d(d), .seg_sel(seg_sel), .dp_en(dp_en), .lzs_en(lzs_en),
        .brightness(brightness), .seg(seg0), .com(com0)
    );

    seg_driver #(.BLANK_CYC(2), .SEG_ACT_LOW(1'b1), .COM_ACT_LOW(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .d(d), .seg_sel(seg_sel), .dp_en(dp_en), .lzs_en(lzs_en),
        .brightness(brightness), .seg(seg2), .com(com2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic on_now();
        return pwm_used < brightness;
    endfunction

    function automatic logic [7:0] exp_seg(input logic [7:0] act);
        return on_now() ? ~act : 8'hFF;
    endfunction

    function automatic logic [7:0] exp_com(input logic [5:0] sel);
        return on_now() ? {2'b00, ~sel} : 8'h3F;
    endfunction

    logic [3:0] lz_val [6];
    int         cnt;

    initial begin
        reset = 1'b1; d = 4'd0; seg_sel = 6'd0; dp_en = 6'd0; lzs_en = 1'b0;
        brightness = 4'd15;
        #1;
        chk("rst_seg0", seg0, 8'hFF);
        chk("rst_com0", {2'b00, com0}, 8'h3F);
        tick(); tick();
        reset = 1'b0;

        // Digit walk with no dead time.
        seg_sel = 6'h01;
        for (int v = 0; v < 16; v++) begin
            d = 4'(v);
            tick(); tick();
            chk($sformatf("walk_seg_%0d", v), seg0, exp_seg({1'b0, tbl[v]}));
            chk($sformatf("walk_com_%0d", v), {2'b00, com0}, exp_com(6'h01));
        end
        cnt = 0;
        repeat (16) begin
            tick();
            if (com0 !== 6'h3F) cnt++;
        end
        chk("duty15", 8'(cnt), 8'd15);

        // Select change: BLANK_CYC=2 blanks two edges, BLANK_CYC=0 shows at once.
        seg_sel = 6'h02;
        tick();
        tick();
        chk("blank_k1_com2", {2'b00, com2}, 8'h3F);
        chk("blank_k1_seg2", seg2, 8'hFF);
        chk("noblank_k1_com0", {2'b00, com0}, exp_com(6'h02));
        tick();
        chk("blank_k2_com2", {2'b00, com2}, 8'h3F);
        tick();
        chk("blank_k3_com2", {2'b00, com2}, exp_com(6'h02));
        chk("blank_k3_seg2", seg2, exp_seg({1'b0, tbl[15]}));

        // Brightness duty.
        brightness = 4'd4;
        tick();
        cnt = 0;
        repeat (16) begin
            tick();
            if (com0 !== 6'h3F) cnt++;
        end
        chk("duty4", 8'(cnt), 8'd4);
        brightness = 4'd0;
        tick();
        cnt = 0;
        repeat (16) begin
            tick();
            if (com0 !== 6'h3F) cnt++;
        end
        chk("duty0", 8'(cnt), 8'd0);
        brightness = 4'd15;

        // Leading-zero suppression, scanning from the top digit down.
        lz_val = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
        lzs_en = 1'b1;
        dp_en  = 6'h20;
        for (int p = 5; p >= 0; p--) begin
            seg_sel = 6'(1 << p);
            d = lz_val[p];
            tick(); tick();
            if (p == 5)      chk("lzs_p5_dp", seg0, exp_seg(8'h80));
            else if (p == 4) chk("lzs_p4", seg0, exp_seg(8'h00));
            else if (p == 3) chk("lzs_p3", seg0, exp_seg({1'b0, tbl[1]}));
            else             chk($sformatf("lzs_p%0d", p), seg0, exp_seg({1'b0, tbl[0]}));
            chk($sformatf("lzs_com_p%0d", p), {2'b00, com0}, exp_com(6'(1 << p)));
        end
        dp_en = 6'h00;
        d = 4'd0;
        for (int p = 5; p >= 0; p--) begin
            seg_sel = 6'(1 << p);
            tick(); tick();
            chk($sformatf("lzs0_p%0d", p), seg0,
                exp_seg(p == 0 ? {1'b0, tbl[0]} : 8'h00));
        end
        lzs_en = 1'b0;

        // No-select codes, then return to a valid select.
        seg_sel = 6'h03; d = 4'd7;
        tick(); tick();
        chk("multi_com2", {2'b00, com2}, 8'h3F);
        chk("multi_seg2", seg2, 8'hFF);
        chk("multi_com0", {2'b00, com0}, 8'h3F);
        tick();
        chk("multi_nowr0", {4'd0, u_dut2.digit_mem_q[0]}, 8'd0);
        chk("multi_nowr1", {4'd0, u_dut2.digit_mem_q[1]}, 8'd0);
        seg_sel = 6'h00;
        tick(); tick();
        chk("zero_com2", {2'b00, com2}, 8'h3F);
        chk("zero_com0", {2'b00, com0}, 8'h3F);
        seg_sel = 6'h04; d = 4'd9;
        tick();
        tick();
        chk("ret_k1_com2", {2'b00, com2}, 8'h3F);
        tick();
        chk("ret_k2_com2", {2'b00, com2}, 8'h3F);
        tick();
        chk("ret_k3_com2", {2'b00, com2}, exp_com(6'h04));
        chk("ret_k3_seg2", seg2, exp_seg({1'b0, tbl[9]}));
        chk("ret_mem2", {4'd0, u_dut2.digit_mem_q[2]}, 8'd9);

        // Asynchronous reset mid-scan, between clock edges.
        seg_sel = 6'h08; d = 4'd5;
        tick(); tick();
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_seg0", seg0, 8'hFF);
        chk("mid_rst_com0", {2'b00, com0}, 8'h3F);
        chk("mid_rst_seg2", seg2, 8'hFF);
        chk("mid_rst_com2", {2'b00, com2}, 8'h3F);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("mid_rst_mem%0d", i), {4'd0, u_dut0.digit_mem_q[i]}, 8'd0);
        end
        tick();
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
